// File: rtl/mod_inv_check_if.sv
`default_nettype none
// ============================================================================
//  Module   : mod_inv_check_if
//  Purpose  : Bundles the request and result signals of mod_inv_check.
//             The requester uses modport master; the checker uses modport slave.
//  Signals  : start              - request to begin a check
//             Multiplicative_Num - operand A (WIDTH bits, unsigned)
//             Multiplicative_Inv - candidate inverse B (WIDTH bits, unsigned)
//             Modular            - modulus N (WIDTH bits, unsigned)
//             busy               - check in progress
//             Product            - (A*B) mod N
//             Inv_Valid          - Product == 1
//             Range_Err          - operand range violation
//             Check_Done         - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
interface mod_inv_check_if #(
   parameter int WIDTH = 512
);
   logic             start;
   logic [WIDTH-1:0] Multiplicative_Num;
   logic [WIDTH-1:0] Multiplicative_Inv;
   logic [WIDTH-1:0] Modular;
   logic             busy;
   logic [WIDTH-1:0] Product;
   logic             Inv_Valid;
   logic             Range_Err;
   logic             Check_Done;

   modport master (
      output start, Multiplicative_Num, Multiplicative_Inv, Modular,
      input  busy, Product, Inv_Valid, Range_Err, Check_Done
   );

   modport slave (
      input  start, Multiplicative_Num, Multiplicative_Inv, Modular,
      output busy, Product, Inv_Valid, Range_Err, Check_Done
   );
endinterface
`default_nettype wire

// File: rtl/mod_inv_check.sv
`default_nettype none
// ============================================================================
//  Module   : mod_inv_check
//  Purpose  : Checks whether B is the multiplicative inverse of A modulo N by
//             computing (A*B) mod N with a bit-serial, MSB-first
//             double-and-add interleaved modular multiplier (one bit of B
//             per cycle). Result is reported WIDTH+1 cycles after start.
//  Ports    : aclk   - clock, rising edge
//             areset - synchronous active-high reset
//             bus    - mod_inv_check_if.slave (start, operands, results)
//  Config   : MOD_INV_CHECK_RANGE_EN - when defined, operands are checked at
//             start (N<2, A>=N or B>=N); a violation skips the multiply and
//             reports Range_Err two cycles after start. When undefined,
//             Range_Err stays 0 and out-of-range Product is meaningless.
//  Note     : WIDTH must equal the WIDTH of the connected interface.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_inv_check #(
   parameter int WIDTH = 512
) (
   input  logic            aclk,
   input  logic            areset,
   mod_inv_check_if.slave  bus
);

   localparam int              IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  n_q;
   logic [WIDTH:0]    p_q;      // one spare bit so 2P and P+A never wrap
   logic [IDX_W-1:0]  idx_q;
   logic              err_q;    // range violation captured at acceptance
   logic              busy_q;
   logic              done_q;
   logic [WIDTH-1:0]  prod_q;
   logic              inv_q;
   logic              rerr_q;

   logic [WIDTH:0]    n_ext;
   logic [WIDTH:0]    a_ext;
   logic [WIDTH:0]    p_dbl;
   logic [WIDTH:0]    p_red1;
   logic [WIDTH:0]    p_add;
   logic [WIDTH:0]    p_d;
   logic              range_bad;

   // One iteration of the interleaved multiplier. With P < N on entry each
   // conditional subtraction restores P < N, so a single subtract suffices.
   always_comb begin
      n_ext  = {1'b0, n_q};
      a_ext  = {1'b0, a_q};
      p_dbl  = p_q << 1;
      p_red1 = (p_dbl >= n_ext) ? (p_dbl - n_ext) : p_dbl;
      p_add  = b_q[idx_q] ? (p_red1 + a_ext) : p_red1;
      p_d    = (p_add >= n_ext) ? (p_add - n_ext) : p_add;
   end

`ifdef MOD_INV_CHECK_RANGE_EN
   assign range_bad = (bus.Modular < WIDTH'(2))
                    || (bus.Multiplicative_Num >= bus.Modular)
                    || (bus.Multiplicative_Inv >= bus.Modular);
`else
   assign range_bad = 1'b0;
`endif

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         n_q     <= '0;
         p_q     <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
         inv_q   <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.Multiplicative_Num;
                  b_q     <= bus.Multiplicative_Inv;
                  n_q     <= bus.Modular;
                  p_q     <= '0;
                  idx_q   <= IDX_MAX;
                  err_q   <= range_bad;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               // A range violation leaves after one pass without iterating,
               // putting Check_Done two cycles after start.
               if (err_q) begin
                  state_q <= S_DONE;
               end else begin
                  p_q <= p_d;
                  if (idx_q == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     idx_q <= idx_q - 1'b1;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
               if (err_q) begin
                  prod_q <= '0;
                  inv_q  <= 1'b0;
                  rerr_q <= 1'b1;
               end else begin
                  prod_q <= p_q[WIDTH-1:0];
                  inv_q  <= (p_q[WIDTH-1:0] == WIDTH'(1));
                  rerr_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.Check_Done = done_q;
   assign bus.Product    = prod_q;
   assign bus.Inv_Valid  = inv_q;
   assign bus.Range_Err  = rerr_q;

endmodule
`default_nettype wire
